// File: rtl/gray_host.sv
// gray_host: on-chip image buffer feeding an LBP engine and holding
// its results for readback once the engine reports completion.
module gray_host #(
  parameter int AW   = 14,
  parameter int NPIX = 16384
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_valid,
  input  logic [7:0]    load_data,
  output logic          load_ready,
  output logic          gray_ready,
  input  logic          gray_req,
  input  logic [AW-1:0] gray_addr,
  output logic [7:0]    gray_data,
  input  logic          lbp_valid,
  input  logic [AW-1:0] lbp_addr,
  input  logic [7:0]    lbp_data,
  input  logic          finish,
  output logic          done,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data,
  output logic [AW-1:0] wr_cnt,
  output logic          err
);

  localparam int HW = AW / 2;
  localparam logic [AW-1:0] LAST = AW'(NPIX - 1);

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    SERVE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] load_cnt;
  logic [7:0]    gray_mem [NPIX];
  logic [7:0]    lbp_mem  [NPIX];

  logic gray_we;
  logic lbp_we;
  logic err_set;

  // Outermost ring of the image has no full 3x3 neighbourhood.
  function automatic logic is_border(input logic [AW-1:0] a);
    logic [HW-1:0] row;
    logic [HW-1:0] col;
    row = a[AW-1:HW];
    col = a[HW-1:0];
    return (row == '0) || (row == '1) ||
           (col == '0) || (col == '1);
  endfunction

  always_comb begin
    state_d    = state_q;
    load_ready = 1'b0;
    gray_ready = 1'b0;
    done       = 1'b0;
    gray_we    = 1'b0;
    lbp_we     = 1'b0;
    err_set    = 1'b0;
    unique case (state_q)
      LOAD: begin
        load_ready = 1'b1;
        gray_we    = load_valid;
        err_set    = gray_req | lbp_valid;
        if (load_valid && load_cnt == LAST)
          state_d = SERVE;
      end
      SERVE: begin
        gray_ready = 1'b1;
        lbp_we     = lbp_valid & ~is_border(lbp_addr);
        err_set    = lbp_valid & is_border(lbp_addr);
        if (finish)
          state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        err_set = lbp_valid;
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (gray_we)
      gray_mem[load_cnt] <= load_data;
    if (lbp_we)
      lbp_mem[lbp_addr] <= lbp_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= LOAD;
      load_cnt  <= '0;
      gray_data <= '0;
      rd_data   <= '0;
      wr_cnt    <= '0;
      err       <= 1'b0;
    end else begin
      state_q <= state_d;
      if (gray_we)
        load_cnt <= load_cnt + 1'b1;
      if (state_q == SERVE && gray_req)
        gray_data <= gray_mem[gray_addr];
      if (state_q == DONE)
        rd_data <= is_border(rd_addr) ? '0 : lbp_mem[rd_addr];
      else
        rd_data <= '0;
      if (lbp_we && wr_cnt != LAST)
        wr_cnt <= wr_cnt + 1'b1;
      if (err_set)
        err <= 1'b1;
    end
  end

endmodule

// File: doc/gray_host.md
GRAY_HOST -- requirements
Module: gray_host

Interface
REQ-001 Parameter: AW, 14, pixel address width; image is 128x128 (2^AW pixels), address = {row[6:0], col[6:0]}.
REQ-002 Parameter: NPIX, 16384, pixels per image (2^AW).
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 load_valid  in  1  image-load pixel strobe, raster order.
REQ-006 load_data  in  8  image-load gray pixel.
REQ-007 load_ready  out  1  block accepts load pixels.
REQ-008 gray_ready  out  1  image resident, LBP engine may start requesting.
REQ-009 gray_req  in  1  engine read request.
REQ-010 gray_addr  in  14  engine read address.
REQ-011 gray_data  out  8  registered gray read data.
REQ-012 lbp_valid  in  1  engine result write strobe.
REQ-013 lbp_addr  in  14  result address.
REQ-014 lbp_data  in  8  result value.
REQ-015 finish  in  1  engine completion flag.
REQ-016 done  out  1  results frozen, readback allowed.
REQ-017 rd_addr  in  14  result readback address.
REQ-018 rd_data  out  8  registered result readback data.
REQ-019 wr_cnt  out  14  number of result writes accepted.
REQ-020 err  out  1  sticky protocol-error flag.

Function
REQ-021 Block SHALL hold two NPIX x 8 arrays: gray_mem (image) and lbp_mem (results).
REQ-022 FSM states: LOAD, SERVE, DONE; reset state LOAD.
REQ-023 LOAD: load_ready=1; each edge with load_valid=1 writes gray_mem[load_cnt] <= load_data, load_cnt += 1.
REQ-024 LOAD -> SERVE on the edge accepting pixel NPIX-1; load_cnt wraps to 0; load_ready=0 from the next cycle.
REQ-025 gray_ready SHALL be 1 exactly while in SERVE (registered, rises the cycle after the last load pixel).
REQ-026 SERVE read: edge with gray_req=1 SHALL load gray_data <= gray_mem[gray_addr] (one-cycle latency); gray_req=0 holds gray_data.
REQ-027 Read addresses are unrestricted; any of 0..NPIX-1 SHALL return stored pixel.
REQ-028 SERVE write: edge with lbp_valid=1 SHALL store lbp_mem[lbp_addr] <= lbp_data and increment wr_cnt (saturating at NPIX-1).
REQ-029 Border address (row 0, row 127, col 0 or col 127) with lbp_valid=1: write suppressed, wr_cnt unchanged, err set.
REQ-030 SERVE -> DONE on edge with finish=1; a simultaneous lbp_valid write SHALL still be performed.
REQ-031 DONE: terminal until reset; gray_ready=0, done=1, further lbp_valid ignored and sets err.
REQ-032 DONE readback: each edge rd_data <= lbp_mem[rd_addr]; border addresses SHALL return 8'd0 regardless of array content.
REQ-033 rd_data SHALL hold 0 outside DONE.
REQ-034 gray_req=1 or lbp_valid=1 while in LOAD SHALL be ignored and set err.
REQ-035 load_valid outside LOAD SHALL be ignored, no error.
REQ-036 err SHALL be sticky until reset.

Reset
REQ-037 reset low SHALL immediately force: state LOAD, load_ready=1, gray_ready=0, gray_data=0, rd_data=0, done=0, err=0, wr_cnt=0, load_cnt=0.
REQ-038 Memory arrays are not cleared by reset; contents after mid-operation reset are don't-care until reloaded.
REQ-039 Reset asserted mid-load or mid-serve SHALL abort; next image load restarts at address 0.

Verification
REQ-040 Load 16384 pixels value=addr[7:0] -> load_ready falls after last, gray_ready=1 next cycle; gray_req addr 0x0081 -> gray_data=0x81 one cycle later.
REQ-041 Back-to-back gray_req addresses 0x0000,0x0001,0x0080 with req every cycle -> gray_data 0x00,0x01,0x80 on consecutive cycles; req=0 holds 0x80.
REQ-042 lbp_valid addr 0x0081 data 0xA5, then finish -> done=1, wr_cnt=1; rd_addr 0x0081 -> rd_data=0xA5; rd_addr 0x0000 -> 0x00.
REQ-043 lbp_valid addr 0x0005 (row 0) data 0xFF -> err=1, wr_cnt unchanged, readback 0x0005 = 0x00.
REQ-044 Connect LBP engine, run full image -> wr_cnt=15876, done=1, err=0, readback matches golden LBP on all interior pixels.
REQ-045 Assert reset at load pixel 5000 -> load_ready=1, gray_ready=0, err=0 immediately; full reload then reaches SERVE normally.
